// File: rtl/dff_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : dff_response_checker
// Description : Monitors a D flip-flop (C, D, Q, nQ) on a fast system clock.
//               It checks Q/nQ a fixed settle time after every C rising edge
//               and flags Q glitches and early edges as timing violations.
//               Define DFF_CHK_SYNC_EN to pass the DUT signals through
//               2-flop synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_response_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             c_i,
    input  logic             d_i,
    input  logic             q_i,
    input  logic             nq_i,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic [3:0]       RELOAD  = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic c_s, d_s, q_s, nq_s;

`ifdef DFF_CHK_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= {c_i, d_i, q_i, nq_i};
            sync2_q <= sync1_q;
        end
    end

    assign {c_s, d_s, q_s, nq_s} = sync2_q;
`else
    assign {c_s, d_s, q_s, nq_s} = {c_i, d_i, q_i, nq_i};
`endif

    state_t           state_q, state_d;
    logic             exp_q, exp_d;
    logic             c_prev_q;
    logic             q_last_q, q_last_d;
    logic [3:0]       settle_q, settle_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       rise;
    logic       start_settle;
    logic       viol;
    logic [1:0] viol_code;

    assign rise = c_s & ~c_prev_q;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        q_last_d     = q_last_q;
        settle_d     = settle_q;
        err_d        = 1'b0;
        code_d       = code_q;
        fail_d       = fail_q;
        edge_cnt_d   = edge_cnt_q;
        err_cnt_d    = err_cnt_q;
        start_settle = 1'b0;
        viol         = 1'b0;
        viol_code    = 2'b00;

        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_WAIT;
                    q_last_d = q_s;
                end
                ST_WAIT: begin
                    if (rise) begin
                        start_settle = 1'b1;
                    end else if (q_s != q_last_q) begin
                        viol      = 1'b1;
                        viol_code = 2'b11;
                        q_last_d  = q_s;
                    end
                end
                ST_SETTLE: begin
                    if (rise) begin
                        viol         = 1'b1;
                        viol_code    = 2'b11;
                        start_settle = 1'b1;
                    end else if (settle_q == 4'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    // Q mismatch outranks the complementary-output fault
                    if (q_s != exp_q) begin
                        viol      = 1'b1;
                        viol_code = 2'b01;
                    end else if (nq_s == q_s) begin
                        viol      = 1'b1;
                        viol_code = 2'b10;
                    end
                    q_last_d     = q_s;
                    state_d      = ST_WAIT;
                    start_settle = rise;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_settle) begin
            state_d    = ST_SETTLE;
            exp_d      = d_s;
            settle_d   = RELOAD;
            edge_cnt_d = (edge_cnt_q == CNT_MAX) ? edge_cnt_q : edge_cnt_q + CNT_ONE;
        end

        if (viol) begin
            err_d     = 1'b1;
            code_d    = viol_code;
            fail_d    = 1'b1;
            err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            exp_q      <= 1'b0;
            c_prev_q   <= 1'b0;
            q_last_q   <= 1'b0;
            settle_q   <= 4'd0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
            fail_q     <= 1'b0;
            edge_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            c_prev_q   <= c_s;
            q_last_q   <= q_last_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            code_q     <= code_d;
            fail_q     <= fail_d;
            edge_cnt_q <= edge_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign fail_o     = fail_q;
    assign edge_cnt_o = edge_cnt_q;
    assign err_cnt_o  = err_cnt_q;
    assign busy_o     = (state_q == ST_SETTLE) || (state_q == ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_dff_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_response_checker
// Description : Bench for dff_response_checker; two instances (SETTLE 2/CNT 8
//               and SETTLE 3/CNT 4) share one directed stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, c = 1'b0, d = 1'b0, q = 1'b0, nq = 1'b1;

    logic       a_err, a_fail, a_busy;
    logic [1:0] a_code;
    logic [7:0] a_ecnt, a_xcnt;
    logic       b_err, b_fail, b_busy;
    logic [1:0] b_code;
    logic [3:0] b_ecnt, b_xcnt;

    dff_response_checker #(.SETTLE_CYC(2), .CNT_W(8)) u_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .c_i(c), .d_i(d), .q_i(q), .nq_i(nq),
        .err_o(a_err), .err_code_o(a_code), .fail_o(a_fail),
        .edge_cnt_o(a_ecnt), .err_cnt_o(a_xcnt), .busy_o(a_busy)
    );

    dff_response_checker #(.SETTLE_CYC(3), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .c_i(c), .d_i(d), .q_i(q), .nq_i(nq),
        .err_o(b_err), .err_code_o(b_code), .fail_o(b_fail),
        .edge_cnt_o(b_ecnt), .err_cnt_o(b_xcnt), .busy_o(b_busy)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: a pending check is a cycle timestamp, not a state.
    int m_pend[2], m_code[2], m_ecnt[2], m_xcnt[2];
    bit m_active[2], m_exp[2], m_qlast[2], m_cprev[2], m_err[2], m_fail[2];
    int SETC[2] = '{2, 3};
    int MAXC[2] = '{255, 15};
    int n = 0;
    bit cmp_on = 1'b0;

    task automatic model_step(input int i);
        bit rise;
        bit viol;
        int code;
        viol = 1'b0;
        code = 0;
        m_err[i] = 1'b0;
        if (rst) begin
            m_active[i] = 0; m_pend[i] = -1; m_exp[i] = 0; m_qlast[i] = 0;
            m_cprev[i] = 0; m_code[i] = 0; m_fail[i] = 0; m_ecnt[i] = 0; m_xcnt[i] = 0;
        end else begin
            rise = c && !m_cprev[i];
            m_cprev[i] = c;
            if (!en) begin
                m_active[i] = 0;
                m_pend[i] = -1;
            end else if (!m_active[i]) begin
                m_active[i] = 1;
                m_qlast[i] = q;
            end else begin
                if (m_pend[i] >= 0 && n == m_pend[i]) begin
                    if (q != m_exp[i]) begin viol = 1; code = 1; end
                    else if (nq == q) begin viol = 1; code = 2; end
                    m_qlast[i] = q;
                    m_pend[i] = -1;
                end else if (m_pend[i] >= 0) begin
                    if (rise) begin viol = 1; code = 3; end
                end else if (!rise && q != m_qlast[i]) begin
                    viol = 1; code = 3; m_qlast[i] = q;
                end
                if (rise) begin
                    m_exp[i] = d;
                    m_pend[i] = n + SETC[i] + 1;
                    if (m_ecnt[i] < MAXC[i]) m_ecnt[i]++;
                end
                if (viol) begin
                    m_err[i] = 1; m_code[i] = code; m_fail[i] = 1;
                    if (m_xcnt[i] < MAXC[i]) m_xcnt[i]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        n++;
        for (int i = 0; i < 2; i++) model_step(i);
        if (rst) cmp_on = 1'b1;
    end

    task automatic cmp_inst(input string nm, input int i, input bit e, input int code,
                            input bit f, input int ec, input int xc, input bit b);
        checks++;
        if (e == m_err[i] && code == m_code[i] && f == m_fail[i] && ec == m_ecnt[i] &&
            xc == m_xcnt[i] && b == (m_pend[i] >= 0))
            passes++;
        else
            $display("FAIL model_%s cyc %0d: got err=%0d code=%0d fail=%0d edge=%0d errcnt=%0d busy=%0d expected err=%0d code=%0d fail=%0d edge=%0d errcnt=%0d busy=%0d",
                     nm, n, e, code, f, ec, xc, b, m_err[i], m_code[i], m_fail[i],
                     m_ecnt[i], m_xcnt[i], (m_pend[i] >= 0));
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_inst("A", 0, a_err, int'(a_code), a_fail, int'(a_ecnt), int'(a_xcnt), a_busy);
            cmp_inst("B", 1, b_err, int'(b_code), b_fail, int'(b_ecnt), int'(b_xcnt), b_busy);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One C pulse; the DUT's response (qv/nqv) appears during the settle window.
    task automatic edge_pulse(input bit dv, input bit qv, input bit nqv);
        d = dv;
        tick();
        c = 1'b1;
        tick();
        q = qv;
        nq = nqv;
        c = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_err", int'(a_err), 0);
        chk("rst_ecnt", int'(a_ecnt), 0);
        chk("rst_fail", int'(b_fail), 0);
        chk("rst_busy", int'(a_busy), 0);
        rst = 1'b0;
        en = 1'b1;
        tick();

        // Correct flip-flop
        edge_pulse(1'b1, 1'b1, 1'b0);
        chk("ok_ecnt", int'(a_ecnt), 1);
        chk("ok_xcnt", int'(a_xcnt), 0);
        chk("ok_fail", int'(a_fail), 0);

        // Q stuck at 0: verdict exactly SETTLE_CYC+1 edges after detection
        q = 1'b0; nq = 1'b1;
        do_reset();
        d = 1'b1;
        tick();
        c = 1'b1;
        tick();
        c = 1'b0;
        tick();
        tick();
        chk("stuck_err_early", int'(a_err), 0);
        tick();
        chk("stuck_err", int'(a_err), 1);
        chk("stuck_code", int'(a_code), 1);
        tick();
        chk("stuck_err_pulse", int'(a_err), 0);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) edge_pulse(i[0] ? 1'b0 : 1'b1, i[0] ? 1'b0 : 1'b1, i[0]);
        chk("stuck_fail_sticky", int'(a_fail), 1);
        chk("stuck_xcnt", int'(a_xcnt), 1);
        chk("stuck_ecnt", int'(a_ecnt), 11);

        // nQ fault
        q = 1'b0; nq = 1'b1;
        do_reset();
        edge_pulse(1'b0, 1'b0, 1'b0);
        chk("nq_code", int'(a_code), 2);
        chk("nq_xcnt", int'(a_xcnt), 1);
        nq = 1'b1;
        tick();

        // Q glitch in WAIT
        do_reset();
        tick();
        q = 1'b1; nq = 1'b0;
        tick();
        chk("glitch_err", int'(a_err), 1);
        chk("glitch_code", int'(a_code), 3);
        tick();

        // Early second edge
        q = 1'b0; nq = 1'b1;
        do_reset();
        tick();
        d = 1'b1;
        c = 1'b1;
        tick();
        c = 1'b0;
        tick();
        c = 1'b1;
        tick();
        chk("early_err", int'(b_err), 1);
        chk("early_code", int'(b_code), 3);
        chk("early_ecnt", int'(b_ecnt), 2);
        c = 1'b0;
        repeat (6) tick();

        // Saturation
        do_reset();
        for (int i = 0; i < 20; i++) edge_pulse(1'b1, 1'b0, 1'b1);
        chk("sat_xcnt", int'(b_xcnt), 15);
        chk("sat_ecnt", int'(b_ecnt), 15);
        chk("sat_ecnt_a", int'(a_ecnt), 20);

        // Reset during SETTLE
        d = 1'b1;
        c = 1'b1;
        tick();
        c = 1'b0;
        rst = 1'b1;
        tick();
        chk("rstmid_err", int'(a_err), 0);
        chk("rstmid_busy", int'(a_busy), 0);
        chk("rstmid_xcnt", int'(a_xcnt), 0);
        chk("rstmid_ecnt", int'(b_ecnt), 0);
        rst = 1'b0;
        repeat (6) tick();

        // Enable while C is already high
        en = 1'b0;
        c = 1'b1;
        do_reset();
        tick();
        en = 1'b1;
        repeat (4) tick();
        chk("en_c_high_ecnt", int'(a_ecnt), 0);
        c = 1'b0;
        tick();
        c = 1'b1;
        tick();
        chk("en_c_rise_ecnt", int'(a_ecnt), 1);
        c = 1'b0;
        repeat (6) tick();

        // Enable dropped mid-check
        d = 1'b0;
        c = 1'b1;
        tick();
        c = 1'b0;
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (6) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
